// File: rtl/traffic_request_sensor.sv
// Purpose: vehicle-detector front end; synchronises and debounces four lane sensors, latches a request per lane until that lane's green is seen, and flags lanes waiting too long.
// Latency: sensor_raw rise -> req rise is 3+DEBOUNCE_CYCLES edges; green_obs rise -> req fall is 3 edges; pending_cnt/any_urgent are cycle-aligned with req/urgent.
// Backpressure: none; ena=0 freezes synchronisers, lane FSMs, counters and outputs.
//
// Ports:
//   clk          system clock
//   rst_n        synchronous active-low reset; takes priority over ena
//   ena          clock enable, 0 holds all state
//   sensor_raw   asynchronous raw lane detectors, bit i = lane i
//   green_obs    asynchronous observed green per lane, from the controller
//   req          latched request per lane, to the controller
//   urgent       lane has been pending for MAX_WAIT cycles (saturated)
//   pending_cnt  number of lanes currently requesting (0..4)
//   any_urgent   OR of urgent
module traffic_request_sensor #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd1000,
    parameter logic [23:0] MAX_WAIT        = 24'd10_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [3:0] sensor_raw,
    input  logic [3:0] green_obs,
    output logic [3:0] req,
    output logic [3:0] urgent,
    output logic [2:0] pending_cnt,
    output logic       any_urgent
);

    localparam int NUM_LANES = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_QUAL    = 2'd1,
        ST_PENDING = 2'd2,
        ST_SERVED  = 2'd3
    } lane_state_e;

    // Two-flop synchronisers for both asynchronous buses.
    logic [3:0] s_meta_q, s_meta_d;
    logic [3:0] s_sync_q, s_sync_d;
    logic [3:0] g_meta_q, g_meta_d;
    logic [3:0] g_sync_q, g_sync_d;

    // Per-lane state and counters.
    lane_state_e state_q [NUM_LANES];
    lane_state_e state_d [NUM_LANES];
    logic [15:0] dcnt_q  [NUM_LANES];
    logic [15:0] dcnt_d  [NUM_LANES];
    logic [23:0] wcnt_q  [NUM_LANES];
    logic [23:0] wcnt_d  [NUM_LANES];

    // Aggregate outputs, registered from next-state values so they line up with req/urgent.
    logic [2:0] pending_cnt_q, pending_cnt_d;
    logic       any_urgent_q,  any_urgent_d;

    logic [3:0] req_nxt;
    logic [3:0] urgent_nxt;

    // ------------------------------------------------------------------
    // Synchroniser next-state
    // ------------------------------------------------------------------
    always_comb begin
        s_meta_d = s_meta_q;
        s_sync_d = s_sync_q;
        g_meta_d = g_meta_q;
        g_sync_d = g_sync_q;
        if (ena) begin
            s_meta_d = sensor_raw;
            s_sync_d = s_meta_q;
            g_meta_d = green_obs;
            g_sync_d = g_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Lane FSMs: next-state and counters
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            state_d[i] = state_q[i];
            dcnt_d[i]  = dcnt_q[i];
            wcnt_d[i]  = wcnt_q[i];

            if (ena) begin
                unique case (state_q[i])
                    ST_IDLE: begin
                        // A sensor hit while the lane already has green is not a request.
                        if (s_sync_q[i] && !g_sync_q[i]) begin
                            state_d[i] = ST_QUAL;
                            dcnt_d[i]  = 16'd0;
                        end
                    end
                    ST_QUAL: begin
                        // Green wins over both bounce rejection and debounce completion.
                        if (g_sync_q[i]) begin
                            state_d[i] = ST_SERVED;
                        end else if (!s_sync_q[i]) begin
                            state_d[i] = ST_IDLE;
                        end else if (dcnt_q[i] == DEBOUNCE_CYCLES - 16'd1) begin
                            state_d[i] = ST_PENDING;
                            wcnt_d[i]  = 24'd0;
                        end else begin
                            dcnt_d[i] = dcnt_q[i] + 16'd1;
                        end
                    end
                    ST_PENDING: begin
                        // Request is latched: the sensor is ignored until green is seen.
                        if (g_sync_q[i]) begin
                            state_d[i] = ST_SERVED;
                            wcnt_d[i]  = 24'd0;
                        end else if (wcnt_q[i] != MAX_WAIT) begin
                            wcnt_d[i] = wcnt_q[i] + 24'd1;
                        end
                    end
                    ST_SERVED: begin
                        // Wait out the green so a car still on the loop cannot re-latch.
                        if (!g_sync_q[i]) begin
                            state_d[i] = ST_IDLE;
                        end
                    end
                    default: begin
                        state_d[i] = ST_IDLE;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state decode of per-lane outputs, feeding the aggregate registers
    // ------------------------------------------------------------------
    always_comb begin
        pending_cnt_d = 3'd0;
        for (int i = 0; i < NUM_LANES; i++) begin
            req_nxt[i]    = (state_d[i] == ST_PENDING);
            urgent_nxt[i] = (state_d[i] == ST_PENDING) && (wcnt_d[i] == MAX_WAIT);
            pending_cnt_d = pending_cnt_d + {2'b00, req_nxt[i]};
        end
        any_urgent_d = |urgent_nxt;
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_meta_q      <= 4'd0;
            s_sync_q      <= 4'd0;
            g_meta_q      <= 4'd0;
            g_sync_q      <= 4'd0;
            pending_cnt_q <= 3'd0;
            any_urgent_q  <= 1'b0;
            for (int i = 0; i < NUM_LANES; i++) begin
                state_q[i] <= ST_IDLE;
                dcnt_q[i]  <= 16'd0;
                wcnt_q[i]  <= 24'd0;
            end
        end else begin
            s_meta_q      <= s_meta_d;
            s_sync_q      <= s_sync_d;
            g_meta_q      <= g_meta_d;
            g_sync_q      <= g_sync_d;
            pending_cnt_q <= pending_cnt_d;
            any_urgent_q  <= any_urgent_d;
            for (int i = 0; i < NUM_LANES; i++) begin
                state_q[i] <= state_d[i];
                dcnt_q[i]  <= dcnt_d[i];
                wcnt_q[i]  <= wcnt_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs, decoded from registered state only
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            req[i]    = (state_q[i] == ST_PENDING);
            urgent[i] = (state_q[i] == ST_PENDING) && (wcnt_q[i] == MAX_WAIT);
        end
    end

    assign pending_cnt = pending_cnt_q;
    assign any_urgent  = any_urgent_q;

endmodule
